sdram_mport_sched: RTL and testbench
====================================

SDRAM_MPORT_SCHED -- requirements
Module: sdram_mport_sched

Interface
REQ-001 SHALL have parameter NUM_WR, default 2: number of write channels (1-8).
REQ-002 SHALL have parameter NUM_RD, default 2: number of read channels (1-8).
REQ-003 SHALL have parameter ASIZE, default 23: SDRAM word-address width.
REQ-004 SHALL have parameter LSIZE, default 9: burst-length width.
REQ-005 SHALL have parameter UWIDTH, default 16: FIFO used-word width.
REQ-006 SHALL have port REF_CLK, input, 1: the single clock; all logic is rising-edge.
REQ-007 SHALL have port RESET, input, 1: asynchronous, active-high reset.
REQ-008 SHALL have ports wr_used, wr_len, wr_start, wr_max, wr_load (input, NUM_WR x UWIDTH/LSIZE/ASIZE/ASIZE/1): per-write-channel FIFO read-side level, burst length, start address, max address, and pointer reload.
REQ-009 SHALL have ports rd_used, rd_len, rd_start, rd_max, rd_load (input, NUM_RD x same widths): per-read-channel FIFO write-side level and controls.
REQ-010 SHALL have ports cmd_req (output, 1), cmd_write (output, 1), cmd_addr (output, ASIZE), cmd_len (output, LSIZE), cmd_ack (input, 1) and cmd_done (input, 1), forming the command-engine handshake.
REQ-011 SHALL have ports wr_grant (output, NUM_WR) and rd_grant (output, NUM_RD), one-hot FIFO-select masks; and busy (output, 1).

Function
REQ-012 SHALL implement states INIT, IDLE, REQ, WAIT, UPDATE.
REQ-013 INIT SHALL copy every channel's start address into its pointer, then go to IDLE after exactly 1 cycle.
REQ-014 In IDLE, a write channel SHALL be eligible when wr_len != 0, wr_used >= wr_len, and wr_load = 0.
REQ-015 In IDLE, a read channel SHALL be eligible when rd_len != 0, rd_used < rd_len, and rd_load = 0.
REQ-016 Any eligible write SHALL beat every read.
REQ-017 Within a class, the winner SHALL be chosen by arbitration (see REQ-030); on no eligible channel, IDLE SHALL hold.
REQ-018 On a grant, the next edge SHALL enter REQ with cmd_req=1, the grant bit set, and cmd_write/cmd_addr/cmd_len registered from the winner, all held stable until cmd_ack.
REQ-019 cmd_ack=1 in REQ SHALL drop cmd_req the next cycle and enter WAIT.
REQ-020 cmd_done SHALL be honoured only in WAIT; it moves to UPDATE.
REQ-021 UPDATE SHALL set the pointer to ptr+len if ptr < max-len (ASIZE-bit unsigned compare), otherwise to start.
REQ-022 UPDATE SHALL clear the grant and busy and return to IDLE; the minimum idle-to-idle time is 4 cycles plus the engine latency.
REQ-023 wr_load/rd_load SHALL reload the pointer from start on the next edge, in any state.
REQ-024 A load on the granted channel SHALL not abort the transaction, and its UPDATE increment SHALL be suppressed.
REQ-025 A load coinciding with UPDATE SHALL win.
REQ-026 busy SHALL be 1 in REQ, WAIT, and UPDATE.

Reset
REQ-027 RESET SHALL force state INIT; cmd_req, cmd_write, busy, wr_grant and rd_grant to 0; cmd_addr, cmd_len and all pointers to 0; and arbitration pointers to channel 0.
REQ-028 RESET asserted mid-transaction SHALL abandon it immediately with no pointer update.
REQ-029 On release, INIT SHALL reload the pointers.

Configuration
REQ-030 With SDRAM_SCHED_RR_EN defined, each class SHALL use round-robin: the search starts at the channel after the last winner of that class, and the last-winner pointer advances only on grant.
REQ-031 Without SDRAM_SCHED_RR_EN, each class SHALL use fixed priority, where the lowest index wins; the arbiter pointer registers SHALL not exist.

Structure
REQ-032 A shared package sdram_sched_pkg SHALL hold the state enum, the default-width constants, and the cmd_write encoding (1=write, 0=read).
REQ-033 A single sub-module sched_rr_arb (parameter N, request vector in, one-hot grant out, advance strobe) SHALL be instantiated once per class.

Verification
REQ-034 NUM_WR=2, wr_len[0]=8, wr_used[0]=8, ack after 2 cycles, done after 10 -> cmd_req 1 cycle after IDLE, cmd_addr=wr_start[0], pointer = start+8 after UPDATE.
REQ-035 Write 0 and read 1 both eligible -> write issued first, read issued on the next IDLE.
REQ-036 RR build, writes 0 and 1 always eligible -> grants alternate 0,1,0,1; non-RR build -> channel 0 every time.
REQ-037 start=0, max=32, len=16 -> pointer sequence 0, 16, 0 (wrap at ptr=16 since 16 !< 16).
REQ-038 rd_load pulsed during WAIT on the granted channel -> transaction completes, pointer = rd_start, not start+len.
REQ-039 RESET pulsed in WAIT -> all outputs 0 immediately; INIT then IDLE; no cmd_req until eligibility.

Source files
------------

// File: rtl/sdram_sched_pkg.sv
// rtl/sdram_sched_pkg.sv - shared types and constants for the SDRAM multi-port scheduler
//
// Holds the scheduler state encoding, the default parameter widths used by
// sdram_mport_sched, and the cmd_write encoding seen by the command engine.
package sdram_sched_pkg;

    typedef enum logic [2:0] {
        ST_INIT   = 3'd0,
        ST_IDLE   = 3'd1,
        ST_REQ    = 3'd2,
        ST_WAIT   = 3'd3,
        ST_UPDATE = 3'd4
    } sched_state_t;

    localparam int DEF_NUM_WR = 2;
    localparam int DEF_NUM_RD = 2;
    localparam int DEF_ASIZE  = 23;
    localparam int DEF_LSIZE  = 9;
    localparam int DEF_UWIDTH = 16;

    localparam logic CMD_WRITE = 1'b1;
    localparam logic CMD_READ  = 1'b0;

endpackage

// File: rtl/sched_rr_arb.sv
// rtl/sched_rr_arb.sv - one-class channel arbiter (round-robin or fixed priority)
//
// Build option: SDRAM_SCHED_RR_EN
//   defined   : round-robin; r_next holds the channel the next search starts
//               from and moves past the winner only when i_adv is strobed.
//   undefined : fixed priority, lowest index wins; no state is kept.
//
// Ports:
//   clk, rst : clock and asynchronous active-high reset
//   i_req    : N-bit request vector (eligible channels)
//   i_adv    : strobe, the current o_gnt is being taken by the scheduler
//   o_gnt    : one-hot grant (all zero when nothing requests)
module sched_rr_arb #(
    parameter int N = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] i_req,
    input  logic         i_adv,
    output logic [N-1:0] o_gnt
);

    logic w_found;

`ifdef SDRAM_SCHED_RR_EN
    localparam int IW = (N > 1) ? $clog2(N) : 1;

    logic [IW-1:0] r_next;
    logic [IW-1:0] w_nxt;

    // Rotating search: first requester at or after r_next, wrapping at N.
    always_comb begin
        o_gnt   = '0;
        w_found = 1'b0;
        w_nxt   = r_next;
        for (int k = 0; k < N; k++) begin
            int j;
            j = int'(r_next) + k;
            if (j >= N) j = j - N;
            if (!w_found && i_req[j]) begin
                o_gnt[j] = 1'b1;
                w_found  = 1'b1;
                w_nxt    = (j + 1 >= N) ? '0 : IW'(j + 1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_next <= '0;
        end else if (i_adv) begin
            r_next <= w_nxt;
        end
    end
`else
    logic w_unused_ok;
    assign w_unused_ok = ^{clk, rst, i_adv};

    always_comb begin
        o_gnt   = '0;
        w_found = 1'b0;
        for (int k = 0; k < N; k++) begin
            if (!w_found && i_req[k]) begin
                o_gnt[k] = 1'b1;
                w_found  = 1'b1;
            end
        end
    end
`endif

endmodule

// File: rtl/sdram_mport_sched.sv
// rtl/sdram_mport_sched.sv - multi-port SDRAM burst scheduler (writes over reads)
//
// Picks one write or read channel whose FIFO can take a full burst, issues a
// single command to the SDRAM command engine, waits for it to finish and then
// advances that channel's address pointer (wrapping back to its start).
//
// Build option: SDRAM_SCHED_RR_EN selects round-robin within each class
// (see sched_rr_arb); the default build uses fixed lowest-index priority.
//
// Ports (per-channel buses are flattened, channel i at [i*W +: W]):
//   REF_CLK, RESET          : clock, asynchronous active-high reset
//   wr_used/len/start/max   : write FIFO level, burst length, address window
//   wr_load                 : reload write pointer from wr_start
//   rd_used/len/start/max   : read FIFO level, burst length, address window
//   rd_load                 : reload read pointer from rd_start
//   cmd_req/write/addr/len  : command to engine, held until cmd_ack
//   cmd_ack, cmd_done       : engine accepted / engine finished
//   wr_grant, rd_grant      : one-hot FIFO select of the channel in service
//   busy                    : a transaction is in flight
module sdram_mport_sched
    import sdram_sched_pkg::*;
#(
    parameter int NUM_WR = DEF_NUM_WR,
    parameter int NUM_RD = DEF_NUM_RD,
    parameter int ASIZE  = DEF_ASIZE,
    parameter int LSIZE  = DEF_LSIZE,
    parameter int UWIDTH = DEF_UWIDTH
) (
    input  logic                     REF_CLK,
    input  logic                     RESET,
    input  logic [NUM_WR*UWIDTH-1:0] wr_used,
    input  logic [NUM_WR*LSIZE-1:0]  wr_len,
    input  logic [NUM_WR*ASIZE-1:0]  wr_start,
    input  logic [NUM_WR*ASIZE-1:0]  wr_max,
    input  logic [NUM_WR-1:0]        wr_load,
    input  logic [NUM_RD*UWIDTH-1:0] rd_used,
    input  logic [NUM_RD*LSIZE-1:0]  rd_len,
    input  logic [NUM_RD*ASIZE-1:0]  rd_start,
    input  logic [NUM_RD*ASIZE-1:0]  rd_max,
    input  logic [NUM_RD-1:0]        rd_load,
    output logic                     cmd_req,
    output logic                     cmd_write,
    output logic [ASIZE-1:0]         cmd_addr,
    output logic [LSIZE-1:0]         cmd_len,
    input  logic                     cmd_ack,
    input  logic                     cmd_done,
    output logic [NUM_WR-1:0]        wr_grant,
    output logic [NUM_RD-1:0]        rd_grant,
    output logic                     busy
);

    // Common width for comparing FIFO levels against burst lengths.
    localparam int CW = (UWIDTH > LSIZE) ? UWIDTH : LSIZE;

    sched_state_t r_state, w_next;

    logic [ASIZE-1:0]  r_wr_ptr [NUM_WR];
    logic [ASIZE-1:0]  r_rd_ptr [NUM_RD];
    logic              r_cmd_req, r_cmd_write;
    logic [ASIZE-1:0]  r_cmd_addr;
    logic [LSIZE-1:0]  r_cmd_len;
    logic [NUM_WR-1:0] r_wr_grant;
    logic [NUM_RD-1:0] r_rd_grant;
    // Set when the channel in service was reloaded mid-transaction, so the
    // pointer it now holds (its start) must not be stepped at UPDATE.
    logic              r_sup;

    logic [NUM_WR-1:0] w_wr_elig, w_wr_win;
    logic [NUM_RD-1:0] w_rd_elig, w_rd_win;
    logic              w_wr_any, w_rd_any, w_idle, w_wr_adv, w_rd_adv;
    logic              w_load_hit;
    logic [ASIZE-1:0]  w_wr_addr, w_rd_addr;
    logic [LSIZE-1:0]  w_wr_len, w_rd_len;

    function automatic logic [ASIZE-1:0] f_step(
        input logic [ASIZE-1:0] ptr,
        input logic [LSIZE-1:0] len,
        input logic [ASIZE-1:0] start,
        input logic [ASIZE-1:0] max_a
    );
        logic [ASIZE-1:0] len_a;
        len_a = ASIZE'(len);
        // Wrap as soon as another full burst would not fit below max.
        return (ptr < (max_a - len_a)) ? (ptr + len_a) : start;
    endfunction

    // ---------------- eligibility and arbitration ----------------
    always_comb begin
        w_wr_elig = '0;
        for (int i = 0; i < NUM_WR; i++) begin
            w_wr_elig[i] = (wr_len[i*LSIZE +: LSIZE] != '0)
                        && (CW'(wr_used[i*UWIDTH +: UWIDTH]) >= CW'(wr_len[i*LSIZE +: LSIZE]))
                        && !wr_load[i];
        end
        w_rd_elig = '0;
        for (int i = 0; i < NUM_RD; i++) begin
            w_rd_elig[i] = (rd_len[i*LSIZE +: LSIZE] != '0)
                        && (CW'(rd_used[i*UWIDTH +: UWIDTH]) < CW'(rd_len[i*LSIZE +: LSIZE]))
                        && !rd_load[i];
        end
    end

    assign w_wr_any = |w_wr_elig;
    assign w_rd_any = |w_rd_elig;
    assign w_idle   = (r_state == ST_IDLE);
    assign w_wr_adv = w_idle && w_wr_any;
    // Reads only advance their arbiter when no write took the slot.
    assign w_rd_adv = w_idle && !w_wr_any && w_rd_any;

    sched_rr_arb #(.N(NUM_WR)) u_wr_arb (
        .clk   (REF_CLK),
        .rst   (RESET),
        .i_req (w_wr_elig),
        .i_adv (w_wr_adv),
        .o_gnt (w_wr_win)
    );

    sched_rr_arb #(.N(NUM_RD)) u_rd_arb (
        .clk   (REF_CLK),
        .rst   (RESET),
        .i_req (w_rd_elig),
        .i_adv (w_rd_adv),
        .o_gnt (w_rd_win)
    );

    // One-hot winner to its pointer and length.
    always_comb begin
        w_wr_addr = '0;
        w_wr_len  = '0;
        for (int i = 0; i < NUM_WR; i++) begin
            if (w_wr_win[i]) begin
                w_wr_addr = w_wr_addr | r_wr_ptr[i];
                w_wr_len  = w_wr_len  | wr_len[i*LSIZE +: LSIZE];
            end
        end
        w_rd_addr = '0;
        w_rd_len  = '0;
        for (int i = 0; i < NUM_RD; i++) begin
            if (w_rd_win[i]) begin
                w_rd_addr = w_rd_addr | r_rd_ptr[i];
                w_rd_len  = w_rd_len  | rd_len[i*LSIZE +: LSIZE];
            end
        end
    end

    assign w_load_hit = (|(wr_load & r_wr_grant)) || (|(rd_load & r_rd_grant));

    // ---------------- state machine ----------------
    always_ff @(posedge REF_CLK or posedge RESET) begin
        if (RESET) begin
            r_state <= ST_INIT;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_INIT:   w_next = ST_IDLE;
            ST_IDLE:   if (w_wr_any || w_rd_any) w_next = ST_REQ;
            ST_REQ:    if (cmd_ack) w_next = ST_WAIT;
            ST_WAIT:   if (cmd_done) w_next = ST_UPDATE;
            ST_UPDATE: w_next = ST_IDLE;
            default:   w_next = ST_INIT;
        endcase
    end

    // ---------------- command and grant registers ----------------
    always_ff @(posedge REF_CLK or posedge RESET) begin
        if (RESET) begin
            r_cmd_req   <= 1'b0;
            r_cmd_write <= 1'b0;
            r_cmd_addr  <= '0;
            r_cmd_len   <= '0;
            r_wr_grant  <= '0;
            r_rd_grant  <= '0;
            r_sup       <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_wr_any) begin
                        r_cmd_req   <= 1'b1;
                        r_cmd_write <= CMD_WRITE;
                        r_cmd_addr  <= w_wr_addr;
                        r_cmd_len   <= w_wr_len;
                        r_wr_grant  <= w_wr_win;
                        r_sup       <= 1'b0;
                    end else if (w_rd_any) begin
                        r_cmd_req   <= 1'b1;
                        r_cmd_write <= CMD_READ;
                        r_cmd_addr  <= w_rd_addr;
                        r_cmd_len   <= w_rd_len;
                        r_rd_grant  <= w_rd_win;
                        r_sup       <= 1'b0;
                    end
                end
                ST_REQ: begin
                    if (cmd_ack)    r_cmd_req <= 1'b0;
                    if (w_load_hit) r_sup     <= 1'b1;
                end
                ST_WAIT: begin
                    if (w_load_hit) r_sup <= 1'b1;
                end
                ST_UPDATE: begin
                    r_wr_grant <= '0;
                    r_rd_grant <= '0;
                end
                default: ;
            endcase
        end
    end

    // ---------------- address pointers ----------------
    // A load (or INIT) always wins over the UPDATE step.
    always_ff @(posedge REF_CLK or posedge RESET) begin
        if (RESET) begin
            for (int i = 0; i < NUM_WR; i++) r_wr_ptr[i] <= '0;
            for (int i = 0; i < NUM_RD; i++) r_rd_ptr[i] <= '0;
        end else begin
            for (int i = 0; i < NUM_WR; i++) begin
                if (r_state == ST_INIT || wr_load[i]) begin
                    r_wr_ptr[i] <= wr_start[i*ASIZE +: ASIZE];
                end else if (r_state == ST_UPDATE && r_wr_grant[i] && !r_sup) begin
                    r_wr_ptr[i] <= f_step(r_wr_ptr[i], wr_len[i*LSIZE +: LSIZE],
                                          wr_start[i*ASIZE +: ASIZE], wr_max[i*ASIZE +: ASIZE]);
                end
            end
            for (int i = 0; i < NUM_RD; i++) begin
                if (r_state == ST_INIT || rd_load[i]) begin
                    r_rd_ptr[i] <= rd_start[i*ASIZE +: ASIZE];
                end else if (r_state == ST_UPDATE && r_rd_grant[i] && !r_sup) begin
                    r_rd_ptr[i] <= f_step(r_rd_ptr[i], rd_len[i*LSIZE +: LSIZE],
                                          rd_start[i*ASIZE +: ASIZE], rd_max[i*ASIZE +: ASIZE]);
                end
            end
        end
    end

    assign cmd_req   = r_cmd_req;
    assign cmd_write = r_cmd_write;
    assign cmd_addr  = r_cmd_addr;
    assign cmd_len   = r_cmd_len;
    assign wr_grant  = r_wr_grant;
    assign rd_grant  = r_rd_grant;
    assign busy      = (r_state == ST_REQ) || (r_state == ST_WAIT) || (r_state == ST_UPDATE);

endmodule

// File: tb/tb_sdram_mport_sched.sv
// tb/tb_sdram_mport_sched.sv - self-checking bench for sdram_mport_sched
module tb_sdram_mport_sched;

    localparam int NW = 2;
    localparam int NR = 2;
    localparam int AW = 23;
    localparam int LW = 9;
    localparam int UW = 16;

    logic              REF_CLK = 1'b0;
    logic              RESET   = 1'b1;
    logic [NW*UW-1:0]  wr_used;
    logic [NW*LW-1:0]  wr_len;
    logic [NW*AW-1:0]  wr_start, wr_max;
    logic [NW-1:0]     wr_load;
    logic [NR*UW-1:0]  rd_used;
    logic [NR*LW-1:0]  rd_len;
    logic [NR*AW-1:0]  rd_start, rd_max;
    logic [NR-1:0]     rd_load;
    logic              cmd_req, cmd_write, cmd_ack, cmd_done, busy;
    logic [AW-1:0]     cmd_addr;
    logic [LW-1:0]     cmd_len;
    logic [NW-1:0]     wr_grant;
    logic [NR-1:0]     rd_grant;

    always #5 REF_CLK = ~REF_CLK;

    sdram_mport_sched #(
        .NUM_WR(NW), .NUM_RD(NR), .ASIZE(AW), .LSIZE(LW), .UWIDTH(UW)
    ) dut (
        .REF_CLK(REF_CLK), .RESET(RESET),
        .wr_used(wr_used), .wr_len(wr_len), .wr_start(wr_start), .wr_max(wr_max), .wr_load(wr_load),
        .rd_used(rd_used), .rd_len(rd_len), .rd_start(rd_start), .rd_max(rd_max), .rd_load(rd_load),
        .cmd_req(cmd_req), .cmd_write(cmd_write), .cmd_addr(cmd_addr), .cmd_len(cmd_len),
        .cmd_ack(cmd_ack), .cmd_done(cmd_done),
        .wr_grant(wr_grant), .rd_grant(rd_grant), .busy(busy)
    );

    typedef struct {
        logic          wr;
        logic [AW-1:0] addr;
        logic [LW-1:0] len;
        logic [NW-1:0] wg;
        logic [NR-1:0] rg;
    } exp_t;

    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;

    task automatic tick();
        @(posedge REF_CLK);
        #1;
    endtask

    task automatic push(input logic wr, input int addr, input int len,
                        input logic [NW-1:0] wg, input logic [NR-1:0] rg);
        exp_t e;
        e.wr = wr; e.addr = AW'(addr); e.len = LW'(len); e.wg = wg; e.rg = rg;
        sb.push_back(e);
    endtask

    task automatic set_wr(input int ch, input int used, input int len, input int start, input int mx);
        wr_used[ch*UW +: UW]  = UW'(used);
        wr_len[ch*LW +: LW]   = LW'(len);
        wr_start[ch*AW +: AW] = AW'(start);
        wr_max[ch*AW +: AW]   = AW'(mx);
    endtask

    task automatic set_rd(input int ch, input int used, input int len, input int start, input int mx);
        rd_used[ch*UW +: UW]  = UW'(used);
        rd_len[ch*LW +: LW]   = LW'(len);
        rd_start[ch*AW +: AW] = AW'(start);
        rd_max[ch*AW +: AW]   = AW'(mx);
    endtask

    task automatic clear_all();
        wr_used = '0; wr_len = '0; wr_start = '0; wr_max = '0; wr_load = '0;
        rd_used = '0; rd_len = '0; rd_start = '0; rd_max = '0; rd_load = '0;
        cmd_ack = 1'b0; cmd_done = 1'b0;
    endtask

    task automatic hold_reset();
        RESET = 1'b1;
        clear_all();
        tick();
        tick();
    endtask

    // Serve one command: compare it against the scoreboard head, then play the
    // engine. load_mode 1 pulses rd_load[load_ch] in WAIT, 2 during UPDATE.
    task automatic run_txn(input string nm, input int ack_dly, input int done_dly,
                           input int load_ch, input int load_mode);
        exp_t e;
        int   n;
        n = 0;
        while (cmd_req !== 1'b1 && n < 40) begin
            tick();
            n++;
        end
        checks++;
        if (cmd_req !== 1'b1) begin
            failures++;
            $display("FAIL %s req_timeout cmd_req=%b required 1", nm, cmd_req);
            return;
        end
        checks++;
        if (sb.size() == 0) begin
            failures++;
            $display("FAIL %s sb_empty unexpected command addr=%0d", nm, cmd_addr);
            return;
        end
        e = sb.pop_front();
        checks++;
        if ({cmd_write, cmd_addr, cmd_len} !== {e.wr, e.addr, e.len}) begin
            failures++;
            $display("FAIL %s cmd got w=%b addr=%0d len=%0d required w=%b addr=%0d len=%0d",
                     nm, cmd_write, cmd_addr, cmd_len, e.wr, e.addr, e.len);
        end
        checks++;
        if ({wr_grant, rd_grant, busy} !== {e.wg, e.rg, 1'b1}) begin
            failures++;
            $display("FAIL %s grant got wg=%b rg=%b busy=%b required wg=%b rg=%b busy=1",
                     nm, wr_grant, rd_grant, busy, e.wg, e.rg);
        end
        // A stray done while still in REQ must be ignored.
        cmd_done = 1'b1;
        repeat (ack_dly) begin
            tick();
            cmd_done = 1'b0;
        end
        checks++;
        if ({cmd_req, cmd_addr, busy} !== {1'b1, e.addr, 1'b1}) begin
            failures++;
            $display("FAIL %s hold got req=%b addr=%0d busy=%b required req=1 addr=%0d busy=1",
                     nm, cmd_req, cmd_addr, busy, e.addr);
        end
        cmd_ack = 1'b1;
        tick();
        cmd_ack = 1'b0;
        checks++;
        if ({cmd_req, busy} !== 2'b01) begin
            failures++;
            $display("FAIL %s after_ack got req=%b busy=%b required req=0 busy=1", nm, cmd_req, busy);
        end
        if (load_mode == 1) begin
            rd_load[load_ch] = 1'b1;
            tick();
            rd_load[load_ch] = 1'b0;
        end
        repeat (done_dly) tick();
        cmd_done = 1'b1;
        tick();
        cmd_done = 1'b0;
        checks++;
        if (busy !== 1'b1) begin
            failures++;
            $display("FAIL %s update_busy got %b required 1", nm, busy);
        end
        if (load_mode == 2) rd_load[load_ch] = 1'b1;
        tick();
        if (load_mode == 2) rd_load[load_ch] = 1'b0;
        checks++;
        if ({busy, cmd_req, wr_grant, rd_grant} !== '0) begin
            failures++;
            $display("FAIL %s back_idle got busy=%b req=%b wg=%b rg=%b required all 0",
                     nm, busy, cmd_req, wr_grant, rd_grant);
        end
    endtask

    task automatic test_reset();
        logic seen;
        hold_reset();
        checks++;
        if ({cmd_req, cmd_write, busy, wr_grant, rd_grant, cmd_addr, cmd_len} !== '0) begin
            failures++;
            $display("FAIL reset_state got req=%b w=%b busy=%b wg=%b rg=%b addr=%0d len=%0d required all 0",
                     cmd_req, cmd_write, busy, wr_grant, rd_grant, cmd_addr, cmd_len);
        end
        RESET = 1'b0;
        seen = 1'b0;
        repeat (6) begin
            tick();
            if (cmd_req !== 1'b0 || busy !== 1'b0) seen = 1'b1;
        end
        checks++;
        if (seen !== 1'b0) begin
            failures++;
            $display("FAIL idle_hold got activity=%b required 0", seen);
        end
    endtask

    task automatic test_single_write();
        int n;
        hold_reset();
        set_wr(0, 8, 8, 100, 1000);
        push(1'b1, 100, 8, 2'b01, 2'b00);
        push(1'b1, 108, 8, 2'b01, 2'b00);
        RESET = 1'b0;
        n = 0;
        while (cmd_req !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        checks++;
        if (n != 2) begin
            failures++;
            $display("FAIL first_latency got %0d edges required 2", n);
        end
        run_txn("single", 2, 10, -1, 0);
        run_txn("single_next", 1, 3, -1, 0);
        set_wr(0, 0, 0, 100, 1000);
    endtask

    task automatic test_write_over_read();
        hold_reset();
        set_wr(0, 8, 8, 300, 5000);
        set_rd(1, 0, 4, 500, 2000);
        push(1'b1, 300, 8, 2'b01, 2'b00);
        push(1'b0, 500, 4, 2'b00, 2'b10);
        RESET = 1'b0;
        run_txn("wr_first", 1, 2, -1, 0);
        set_wr(0, 0, 0, 300, 5000);
        run_txn("rd_next", 1, 2, -1, 0);
        set_rd(1, 0, 0, 500, 2000);
    endtask

    task automatic test_arb();
        hold_reset();
        set_wr(0, 4, 4, 'h1000, 'h8000);
        set_wr(1, 4, 4, 'h2000, 'h8000);
`ifdef SDRAM_SCHED_RR_EN
        push(1'b1, 'h1000, 4, 2'b01, 2'b00);
        push(1'b1, 'h2000, 4, 2'b10, 2'b00);
        push(1'b1, 'h1004, 4, 2'b01, 2'b00);
        push(1'b1, 'h2004, 4, 2'b10, 2'b00);
`else
        push(1'b1, 'h1000, 4, 2'b01, 2'b00);
        push(1'b1, 'h1004, 4, 2'b01, 2'b00);
        push(1'b1, 'h1008, 4, 2'b01, 2'b00);
        push(1'b1, 'h100C, 4, 2'b01, 2'b00);
`endif
        RESET = 1'b0;
        for (int i = 0; i < 4; i++) run_txn("arb", 1, 1, -1, 0);
    endtask

    task automatic test_wrap();
        hold_reset();
        set_rd(0, 0, 16, 0, 32);
        push(1'b0, 0, 16, 2'b00, 2'b01);
        push(1'b0, 16, 16, 2'b00, 2'b01);
        push(1'b0, 0, 16, 2'b00, 2'b01);
        RESET = 1'b0;
        for (int i = 0; i < 3; i++) run_txn("wrap", 1, 2, -1, 0);
    endtask

    task automatic test_load();
        hold_reset();
        set_rd(1, 3, 8, 64, 1000);
        push(1'b0, 64, 8, 2'b00, 2'b10);
        push(1'b0, 72, 8, 2'b00, 2'b10);
        push(1'b0, 64, 8, 2'b00, 2'b10);
        push(1'b0, 64, 8, 2'b00, 2'b10);
        RESET = 1'b0;
        run_txn("load_pre", 1, 2, -1, 0);
        run_txn("load_wait", 1, 2, 1, 1);
        run_txn("load_update", 1, 2, 1, 2);
        run_txn("load_after", 1, 2, -1, 0);
    endtask

    task automatic test_reset_mid();
        exp_t e;
        int   n;
        logic seen;
        hold_reset();
        set_wr(0, 8, 8, 200, 5000);
        push(1'b1, 200, 8, 2'b01, 2'b00);
        RESET = 1'b0;
        n = 0;
        while (cmd_req !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        e = sb.pop_front();
        checks++;
        if ({cmd_req, cmd_addr} !== {1'b1, e.addr}) begin
            failures++;
            $display("FAIL mid_issue got req=%b addr=%0d required req=1 addr=%0d", cmd_req, cmd_addr, e.addr);
        end
        cmd_ack = 1'b1;
        tick();
        cmd_ack = 1'b0;
        #3;
        RESET = 1'b1;
        #1;
        checks++;
        if ({cmd_req, cmd_write, busy, wr_grant, rd_grant, cmd_addr, cmd_len} !== '0) begin
            failures++;
            $display("FAIL mid_reset got req=%b w=%b busy=%b wg=%b addr=%0d len=%0d required all 0",
                     cmd_req, cmd_write, busy, wr_grant, cmd_addr, cmd_len);
        end
        set_wr(0, 0, 0, 200, 5000);
        tick();
        RESET = 1'b0;
        seen = 1'b0;
        repeat (6) begin
            tick();
            if (cmd_req !== 1'b0) seen = 1'b1;
        end
        checks++;
        if (seen !== 1'b0) begin
            failures++;
            $display("FAIL mid_quiet got req_seen=%b required 0", seen);
        end
        set_wr(0, 8, 8, 200, 5000);
        push(1'b1, 200, 8, 2'b01, 2'b00);
        run_txn("after_reset", 1, 2, -1, 0);
    endtask

    initial begin
        clear_all();
        test_reset();
        test_single_write();
        test_write_over_read();
        test_arb();
        test_wrap();
        test_load();
        test_reset_mid();
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL sb_leftover got %0d entries required 0", sb.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1);
    end

endmodule
